// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: enables a byte-serial image source for exactly one frame at a time
// and packs the returned R,G,B byte stream into 24-bit pixels tagged with x/y and SOF/EOF.
module frame_capture_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int FCNT_W   = 16,
  parameter int DRAIN_TO = 8,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic              camera_en,
  input  logic              data_valid,
  input  logic [7:0]        data_in,
  output logic              pix_valid,
  output logic [23:0]       pix_rgb,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted,
  output logic              err,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int TOTAL = 3 * IMG_W * IMG_H;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(DRAIN_TO + 1);

  localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C     = CW'(TOTAL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] en_cnt;
  logic [CW-1:0] rx_cnt;
  logic [DW-1:0] drain_cnt;
  logic [1:0]    phase;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    r_byte;
  logic [7:0]    g_byte;

  logic byte_acc;     // byte counted towards the current frame
  logic rx_complete;  // frame complete, including a final byte arriving this cycle
  logic load_frame;   // clear counters and (re)enter RUN
  logic frame_end;
  logic abort_hit;
  logic timeout;

  // Abort wins over any byte in the same cycle, so a half-built pixel is never emitted.
  assign byte_acc    = data_valid && (state != S_IDLE) && (rx_cnt != TOTAL_C) && !abort;
  assign rx_complete = (rx_cnt == TOTAL_C) || (byte_acc && (rx_cnt == LAST_C));
  assign busy        = (state != S_IDLE);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    load_frame = 1'b0;
    frame_end  = 1'b0;
    abort_hit  = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = S_RUN;
          load_frame = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state = S_IDLE;
          abort_hit  = 1'b1;
        end else if (en_cnt == LAST_C) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          next_state = S_IDLE;
          abort_hit  = 1'b1;
        end else if (rx_complete) begin
          frame_end = 1'b1;
          if (cont) begin
            next_state = S_RUN;
            load_frame = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end else if (drain_cnt == DRAIN_LAST) begin
          next_state = S_IDLE;
          timeout    = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      camera_en   <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
      frame_count <= '0;
      en_cnt      <= '0;
      drain_cnt   <= '0;
    end else begin
      state      <= next_state;
      camera_en  <= (next_state == S_RUN);
      frame_done <= frame_end;
      aborted    <= abort_hit;
      if (timeout) begin
        err <= 1'b1;
      end else if (load_frame && (state == S_IDLE)) begin
        err <= 1'b0;
      end
      if (frame_end) begin
        frame_count <= frame_count + FCNT_W'(1);
      end
      if (load_frame) begin
        en_cnt <= '0;
      end else if (state == S_RUN) begin
        en_cnt <= en_cnt + CW'(1);
      end
      drain_cnt <= (state == S_DRAIN && next_state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // Byte packing: R and G are held until the B byte completes the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt    <= '0;
      phase     <= '0;
      x         <= '0;
      y         <= '0;
      r_byte    <= '0;
      g_byte    <= '0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eof   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eof   <= 1'b0;

      if (byte_acc) begin
        case (phase)
          2'd0:    r_byte <= data_in;
          2'd1:    g_byte <= data_in;
          default: begin
            pix_valid <= 1'b1;
            pix_rgb   <= {r_byte, g_byte, data_in};
            pix_x     <= x;
            pix_y     <= y;
            pix_sof   <= (x == '0) && (y == '0);
            pix_eof   <= (x == X_LAST) && (y == Y_LAST);
          end
        endcase
      end

      // A restart on the final byte of a frame takes priority over the coordinate advance.
      if (load_frame) begin
        rx_cnt <= '0;
        phase  <= '0;
        x      <= '0;
        y      <= '0;
      end else if (abort_hit) begin
        phase <= '0;
      end else if (byte_acc) begin
        rx_cnt <= rx_cnt + CW'(1);
        phase  <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        if (phase == 2'd2) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized bench for frame_capture_ctrl: a latency-1 image source feeds the DUT and
// each scenario is scored against pixels and frame statistics computed from the sent bytes.
module tb_frame_capture_ctrl;

  localparam int W        = 4;
  localparam int H        = 2;
  localparam int TOTAL    = 3 * W * H;
  localparam int DRAIN_TO = 8;
  localparam int FCNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              abort = 1'b0;
  logic              data_valid = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic              camera_en;
  logic              pix_valid;
  logic [23:0]       pix_rgb;
  logic [1:0]        pix_x;
  logic [0:0]        pix_y;
  logic              pix_sof;
  logic              pix_eof;
  logic              busy;
  logic              frame_done;
  logic              aborted;
  logic              err;
  logic [FCNT_W-1:0] frame_count;

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .IMG_W(W), .IMG_H(H), .FCNT_W(FCNT_W), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .camera_en(camera_en), .data_valid(data_valid), .data_in(data_in),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .busy(busy), .frame_done(frame_done),
    .aborted(aborted), .err(err), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source model state
  bit         en_prev   = 1'b0;
  bit         withhold2 = 1'b0;
  bit         seq_mode  = 1'b0;
  bit         capturing = 1'b1;
  int         src_idx   = 0;
  int         emitted   = 0;
  logic [7:0] sent[$];

  // Monitor state
  logic [28:0] obs[$];
  int          en_runs[$];
  int          en_gaps[$];
  int          cur_run = 0;
  int          cur_gap = 0;
  bit          seen_run = 1'b0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          busy_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) obs.push_back({pix_rgb, pix_x, pix_y, pix_sof, pix_eof});
      if (frame_done) done_cnt++;
      if (aborted) abort_cnt++;
      if (busy) busy_cyc++;
      if (camera_en) begin
        if (seen_run && cur_gap > 0) en_gaps.push_back(cur_gap);
        cur_gap  = 0;
        cur_run++;
        seen_run = 1'b1;
      end else begin
        if (cur_run > 0) en_runs.push_back(cur_run);
        cur_run = 0;
        if (seen_run) cur_gap++;
      end
    end
  end

  task automatic clear_all();
    sent.delete();
    obs.delete();
    en_runs.delete();
    en_gaps.delete();
    cur_run   = 0;
    cur_gap   = 0;
    seen_run  = 1'b0;
    done_cnt  = 0;
    abort_cnt = 0;
    busy_cyc  = 0;
    emitted   = 0;
    src_idx   = 0;
    capturing = 1'b1;
  endtask

  // One clock: drive inputs for the coming cycle, then advance to just after the edge.
  // The source answers each enable cycle with one byte in the following cycle.
  task automatic step(input bit st, input bit ab);
    bit emit;
    start = st;
    abort = ab;
    emit  = en_prev && !(withhold2 && (src_idx % TOTAL) >= TOTAL - 2);
    data_valid = emit;
    if (emit && seq_mode) data_in = 8'(src_idx % TOTAL);
    else                  data_in = 8'($urandom);
    if (ab) capturing = 1'b0;
    if (emit && capturing) begin
      sent.push_back(data_in);
      emitted++;
    end
    if (en_prev) src_idx++;
    en_prev = camera_en;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      step(1'b0, 1'b0);
      n++;
    end
    check({tag, "_idle_reached"}, busy, 0);
    repeat (3) step(1'b0, 1'b0);
  endtask

  // Expected pixels: sent bytes grouped by three, raster position restarting every frame.
  task automatic check_pixels(input string tag);
    int          np;
    int          p;
    logic [1:0]  ex;
    logic [0:0]  ey;
    logic [28:0] e;
    np = sent.size() / 3;
    check({tag, "_npix"}, obs.size(), np);
    for (int i = 0; i < np && i < obs.size(); i++) begin
      p  = i % (W * H);
      ex = 2'(p % W);
      ey = 1'(p / W);
      e  = {sent[3*i], sent[3*i+1], sent[3*i+2], ex, ey, (p == 0), (p == W * H - 1)};
      check($sformatf("%s_pix%0d", tag, i), obs[i], e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fc_exp;
    int n;
    int k;
    int nf;
    fc_exp = 0;

    // Reset state
    #3;
    check("rst_camera_en", camera_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_err", err, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // Single frame, bytes 0x00..0x17
    clear_all();
    seq_mode = 1'b1;
    cont = 1'b0;
    step(1'b1, 1'b0);
    run_until_idle("single", 200);
    fc_exp++;
    check_pixels("single");
    check("single_first", obs[0], {24'h000102, 2'd0, 1'd0, 1'b1, 1'b0});
    check("single_last", obs[7], {24'h151617, 2'd3, 1'd1, 1'b0, 1'b1});
    check("single_en_runs", en_runs.size(), 1);
    check("single_en_len", en_runs[0], TOTAL);
    check("single_done", done_cnt, 1);
    check("single_fcount", frame_count, fc_exp);
    check("single_busy_cyc", busy_cyc, TOTAL + 1);
    check("single_err", err, 0);
    check("single_aborted", abort_cnt, 0);

    // Continuous capture, random byte values
    for (int r = 0; r < 2; r++) begin
      clear_all();
      seq_mode = 1'b0;
      nf = (r == 0) ? 3 : int'($urandom_range(2, 4));
      cont = 1'b1;
      step(1'b1, 1'b0);
      n = 0;
      while (busy && n < 60 * nf) begin
        if (done_cnt >= nf - 1) cont = 1'b0;
        step(1'b0, 1'b0);
        n++;
      end
      check("cont_idle_reached", busy, 0);
      repeat (3) step(1'b0, 1'b0);
      fc_exp += nf;
      check_pixels("cont");
      check("cont_done", done_cnt, nf);
      check("cont_fcount", frame_count, fc_exp);
      check("cont_en_runs", en_runs.size(), nf);
      for (int i = 0; i < en_runs.size(); i++) check($sformatf("cont_en_len%0d", i), en_runs[i], TOTAL);
      check("cont_gaps", en_gaps.size(), nf - 1);
      for (int i = 0; i < en_gaps.size(); i++) check($sformatf("cont_gap%0d", i), en_gaps[i], 1);
    end

    // Abort after k bytes: first the 10-byte case, then random points across RUN and DRAIN
    for (int r = 0; r < 4; r++) begin
      clear_all();
      seq_mode = 1'b0;
      k = (r == 0) ? 10 : int'($urandom_range(1, TOTAL - 1));
      step(1'b1, 1'b0);
      n = 0;
      while (emitted < k && n < 100) begin
        step(1'b0, 1'b0);
        n++;
      end
      check("abort_bytes_sent", emitted, k);
      step(1'b0, 1'b1);
      check("abort_camera_en", camera_en, 0);
      check("abort_busy", busy, 0);
      repeat (4) step(1'b0, 1'b0);
      check_pixels($sformatf("abort_k%0d", k));
      check("abort_pulses", abort_cnt, 1);
      check("abort_done", done_cnt, 0);
      check("abort_fcount", frame_count, fc_exp);
    end

    // Source withholds the last two bytes: drain timeout
    clear_all();
    withhold2 = 1'b1;
    step(1'b1, 1'b0);
    run_until_idle("tmo", 200);
    check_pixels("tmo");
    check("tmo_err", err, 1);
    check("tmo_done", done_cnt, 0);
    check("tmo_fcount", frame_count, fc_exp);
    check("tmo_busy_cyc", busy_cyc, TOTAL + DRAIN_TO);
    withhold2 = 1'b0;
    clear_all();
    step(1'b1, 1'b0);
    check("tmo_err_cleared", err, 0);
    run_until_idle("tmo_next", 200);
    fc_exp++;
    check_pixels("tmo_next");
    check("tmo_next_fcount", frame_count, fc_exp);
    check("tmo_next_err", err, 0);

    // start and abort together in IDLE
    clear_all();
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    check("sa_busy", busy, 0);
    check("sa_en_cycles", en_runs.size() + cur_run, 0);
    check("sa_aborted", abort_cnt, 0);
    check("sa_fcount", frame_count, fc_exp);

    // Reset mid-RUN, timed to land while a pixel strobe is high
    clear_all();
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_camera_en", camera_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_pix_valid", pix_valid, 0);
    check("mrst_fcount", frame_count, 0);
    fc_exp = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_prev = 1'b0;
    clear_all();
    step(1'b1, 1'b0);
    run_until_idle("mrst_next", 200);
    fc_exp++;
    check_pixels("mrst_next");
    check("mrst_next_done", done_cnt, 1);
    check("mrst_next_fcount", frame_count, fc_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
